// File: rtl/multi_debounce_if.sv
// -----------------------------------------------------------------------------
// multi_debounce_if
//
// Purpose:
//    Bundles the per-channel button signals of the multi-channel debouncer so
//    the front end and the display/counter logic share one connection point.
//
// Signals (CHANNELS bits wide unless noted):
//    enable  1 bit  high = prescaler and debounce counters advance
//    in             raw asynchronous button inputs
//    level          debounced pressed state (1 = pressed)
//    rise           one-cycle strobe on level 0->1
//    fall           one-cycle strobe on level 1->0
//    hold           long-press flag
//
// Modports:
//    master  drives enable/in, observes the debounced outputs
//    slave   the debouncer itself
// -----------------------------------------------------------------------------
interface multi_debounce_if #(
   parameter int CHANNELS = 4
);

   logic                enable;
   logic [CHANNELS-1:0] in;
   logic [CHANNELS-1:0] level;
   logic [CHANNELS-1:0] rise;
   logic [CHANNELS-1:0] fall;
   logic [CHANNELS-1:0] hold;

   modport master (
      output enable,
      output in,
      input  level,
      input  rise,
      input  fall,
      input  hold
   );

   modport slave (
      input  enable,
      input  in,
      output level,
      output rise,
      output fall,
      output hold
   );

endinterface

// File: rtl/multi_debounce.sv
// -----------------------------------------------------------------------------
// multi_debounce
//
// Purpose:
//    N-channel button debouncer for the button-tester front end. Every channel
//    is brought into the clock domain with a two-flop synchroniser, sampled on
//    a shared prescaled tick, and only changes its debounced level after the
//    new value has been seen on STABLE_SAMPLES consecutive ticks. A single
//    agreeing sample throws away any progress, which rejects contact bounce.
//    Each channel also produces press/release strobes and a long-press flag.
//
// Parameters:
//    CHANNELS        number of independent button inputs (>= 1)
//    TICK_DIV        clock cycles per sample tick (>= 1)
//    STABLE_SAMPLES  consecutive differing samples needed to change level
//    HOLD_SAMPLES    samples of sustained press before hold asserts
//    INVERT          per-channel mask, bit set = that button is active-low
//
// Ports:
//    clock    in   system clock, all logic on the rising edge
//    reset_n  in   asynchronous active-low reset
//    bus      slave side of multi_debounce_if (enable, in, level, rise,
//                  fall, hold)
// -----------------------------------------------------------------------------
module multi_debounce #(
   parameter int                  CHANNELS       = 4,
   parameter int                  TICK_DIV       = 300,
   parameter int                  STABLE_SAMPLES = 4,
   parameter int                  HOLD_SAMPLES   = 1000,
   parameter logic [CHANNELS-1:0] INVERT         = {CHANNELS{1'b0}}
) (
   input  logic            clock,
   input  logic            reset_n,
   multi_debounce_if.slave bus
);

   // Counter widths. The prescaler and stable counters never need to reach
   // their parameter value itself, so $clog2 of the parameter is enough; a
   // parameter of 1 would give width 0, hence the floor of 1. The hold
   // counter has to represent HOLD_SAMPLES exactly, so it is sized on +1.
   localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int STB_W  = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
   localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES + 1) : 1;

   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [STB_W-1:0]  STB_LAST = STB_W'(STABLE_SAMPLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_SAMPLES);

   logic [CHANNELS-1:0] sync_meta;
   logic [CHANNELS-1:0] sync_q;
   logic [CHANNELS-1:0] raw;

   logic [PRE_W-1:0]    pre_cnt;
   logic                tick;

   logic [STB_W-1:0]    stable_cnt [CHANNELS];
   logic [STB_W-1:0]    stable_nxt [CHANNELS];
   logic [HOLD_W-1:0]   hold_cnt   [CHANNELS];
   logic [HOLD_W-1:0]   hold_nxt   [CHANNELS];

   logic [CHANNELS-1:0] flip;
   logic [CHANNELS-1:0] level_q;
   logic [CHANNELS-1:0] rise_q;
   logic [CHANNELS-1:0] fall_q;
   logic [CHANNELS-1:0] hold_q;

   // Two-flop synchroniser for the asynchronous button pins. It keeps
   // running while enable is low so that re-enabling never acts on a stale
   // sample that was captured before the freeze.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= bus.in;
         sync_q    <= sync_meta;
      end
   end

   // Polarity is normalised after synchronisation, so from here on a 1
   // always means "pressed". Reset clears the flops to 0 regardless of
   // INVERT, which means an active-low button reads as pressed until the
   // synchroniser has seen its idle-high pin; the stable counter hides that.
   assign raw = sync_q ^ INVERT;

   // Shared sample-rate prescaler. It counts enabled cycles 0..TICK_DIV-1 and
   // the tick is the single enabled cycle where it sits on its last value.
   // With TICK_DIV = 1 the counter stays at 0 and every enabled cycle ticks.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
      end else if (bus.enable) begin
         if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
         end
      end
   end

   assign tick = bus.enable && (pre_cnt == PRE_LAST);

   // A channel flips its level on a tick when the sample still disagrees
   // with the current level and this is the last sample the counter was
   // waiting for. Everything that has to move together with the level
   // (strobes, counter clears, hold drop) keys off this one vector.
   always_comb begin
      flip = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         flip[i] = tick && (raw[i] != level_q[i]) && (stable_cnt[i] == STB_LAST);
      end
   end

   // Next values for the per-channel counters, only committed on a tick.
   // The stable counter restarts whenever the sample agrees with the level
   // (glitch rejection) or when the level has just been updated. The hold
   // counter only climbs while the channel was already pressed and stays
   // pressed through this tick, so the rising tick itself does not count and
   // a release clears it on the very tick the level falls.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         stable_nxt[i] = stable_cnt[i];
         hold_nxt[i]   = hold_cnt[i];

         if ((raw[i] == level_q[i]) || (stable_cnt[i] == STB_LAST)) begin
            stable_nxt[i] = '0;
         end else begin
            stable_nxt[i] = stable_cnt[i] + STB_W'(1);
         end

         if (!level_q[i] || flip[i]) begin
            hold_nxt[i] = '0;
         end else if (hold_cnt[i] != HOLD_MAX) begin
            hold_nxt[i] = hold_cnt[i] + HOLD_W'(1);
         end
      end
   end

   // Debounce state. Level, rise and fall update on the same edge, and the
   // strobes default to 0 so they last exactly one clock and stay quiet
   // whenever enable is low. Counters and the hold flag only move on a tick,
   // so a frozen block keeps its progress and resumes exactly where it was.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         hold_q  <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            stable_cnt[i] <= '0;
            hold_cnt[i]   <= '0;
         end
      end else begin
         level_q <= level_q ^ flip;
         rise_q  <= flip & raw;
         fall_q  <= flip & ~raw;
         if (tick) begin
            for (int i = 0; i < CHANNELS; i++) begin
               stable_cnt[i] <= stable_nxt[i];
               hold_cnt[i]   <= hold_nxt[i];
               hold_q[i]     <= (hold_nxt[i] == HOLD_MAX);
            end
         end
      end
   end

   assign bus.level = level_q;
   assign bus.rise  = rise_q;
   assign bus.fall  = fall_q;
   assign bus.hold  = hold_q;

endmodule
